// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer.
// Optional misaligned-fetch check is enabled by defining PC_ALIGN_CHECK_EN.
package pc_fetch_ctrl_pkg;

   localparam int unsigned CPU_WIDTH  = 32;
   localparam int unsigned INST_WIDTH = 32;

   localparam logic [CPU_WIDTH-1:0] RESET_PC_DEFAULT = CPU_WIDTH'(0);
   localparam logic [CPU_WIDTH-1:0] PC_INCR          = CPU_WIDTH'(4);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_DROP = 3'd4
`ifdef PC_ALIGN_CHECK_EN
      ,
      ST_ERR  = 3'd5
`endif
   } fetch_state_e;

   // Instruction presented to decode, with the PC it was fetched from
   typedef struct packed {
      logic [CPU_WIDTH-1:0]  pc;
      logic [INST_WIDTH-1:0] data;
   } fetch_inst_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus: redirect inputs, imem request/response, decode handshake.
// master = fetch sequencer, slave = surrounding core / imem / decode.
interface pc_fetch_ctrl_if;
   import pc_fetch_ctrl_pkg::*;

   logic                  ena;
   logic [CPU_WIDTH-1:0]  curr_pc;
   logic                  trap_valid;
   logic [CPU_WIDTH-1:0]  trap_vec;
   logic                  br_taken;
   logic [CPU_WIDTH-1:0]  br_target;
   logic                  if_req_valid;
   logic                  if_req_ready;
   logic [CPU_WIDTH-1:0]  if_req_addr;
   logic                  if_rsp_valid;
   logic [INST_WIDTH-1:0] if_rsp_data;
   logic                  inst_valid;
   logic                  inst_ready;
   logic [INST_WIDTH-1:0] inst_data;
   logic [CPU_WIDTH-1:0]  inst_pc;
   logic                  fetch_misalign;

   modport master (
      output ena, curr_pc, if_req_valid, if_req_addr,
             inst_valid, inst_data, inst_pc, fetch_misalign,
      input  trap_valid, trap_vec, br_taken, br_target,
             if_req_ready, if_rsp_valid, if_rsp_data, inst_ready
   );

   modport slave (
      input  ena, curr_pc, if_req_valid, if_req_addr,
             inst_valid, inst_data, inst_pc, fetch_misalign,
      output trap_valid, trap_vec, br_taken, br_target,
             if_req_ready, if_rsp_valid, if_rsp_data, inst_ready
   );

endinterface

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// Next-PC priority mux: trap > branch/jump > sequential (+4) > hold.
module pc_fetch_ctrl_pc_next_sel
   import pc_fetch_ctrl_pkg::*;
(
   input  logic                 redir_en_i,
   input  logic                 trap_valid_i,
   input  logic [CPU_WIDTH-1:0] trap_vec_i,
   input  logic                 br_taken_i,
   input  logic [CPU_WIDTH-1:0] br_target_i,
   input  logic                 seq_adv_i,
   input  logic [CPU_WIDTH-1:0] curr_pc_i,
   output logic [CPU_WIDTH-1:0] next_pc_o,
   output logic                 redirect_o
);

   logic redirect;

   always_comb begin
      redirect  = redir_en_i & (trap_valid_i | br_taken_i);
      next_pc_o = curr_pc_i;
      if (redirect) begin
         next_pc_o = trap_valid_i ? trap_vec_i : br_target_i;
      end else if (seq_adv_i) begin
         next_pc_o = curr_pc_i + PC_INCR;
      end
      redirect_o = redirect;
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, one outstanding imem fetch, drops stale responses.
// Define PC_ALIGN_CHECK_EN to trap misaligned fetch PCs into the ERR state.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [CPU_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input logic              clk,
   input logic              rst_n,
   pc_fetch_ctrl_if.master  bus
);

   fetch_state_e         state_q, state_d;
   logic [CPU_WIDTH-1:0] pc_q, pc_d;
   logic                 ena_q;
   logic                 req_valid_q;
   logic                 inst_valid_q;
   fetch_inst_t          inst_q;
   logic                 redirect;
   logic                 seq_adv;

   assign seq_adv = (state_q == ST_HOLD) && bus.inst_ready;

   pc_fetch_ctrl_pc_next_sel u_next_sel (
      .redir_en_i   (state_q != ST_IDLE),
      .trap_valid_i (bus.trap_valid),
      .trap_vec_i   (bus.trap_vec),
      .br_taken_i   (bus.br_taken),
      .br_target_i  (bus.br_target),
      .seq_adv_i    (seq_adv),
      .curr_pc_i    (pc_q),
      .next_pc_o    (pc_d),
      .redirect_o   (redirect)
   );

   // Next state; a redirect always beats a same-cycle handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (bus.if_req_ready) state_d = redirect ? ST_DROP : ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect)              state_d = bus.if_rsp_valid ? ST_REQ : ST_DROP;
            else if (bus.if_rsp_valid) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (redirect || bus.inst_ready) state_d = ST_REQ;
         end
         // The stale response retires the outstanding fetch even if a redirect lands with it
         ST_DROP: begin
            if (bus.if_rsp_valid) state_d = ST_REQ;
         end
`ifdef PC_ALIGN_CHECK_EN
         ST_ERR: begin
            if (redirect) state_d = ST_REQ;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
`ifdef PC_ALIGN_CHECK_EN
      // Checked on entry to REQ so a misaligned address is never put on the bus
      if ((state_d == ST_REQ) && (pc_d[1:0] != 2'b00)) state_d = ST_ERR;
`endif
   end

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         ena_q        <= 1'b0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
`ifdef PC_ALIGN_CHECK_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ena_q        <= 1'b1;
         req_valid_q  <= (state_d == ST_REQ);
         inst_valid_q <= (state_d == ST_HOLD);
         if ((state_q == ST_WAIT) && (state_d == ST_HOLD)) begin
            inst_q <= '{pc: pc_q, data: bus.if_rsp_data};
         end
`ifdef PC_ALIGN_CHECK_EN
         misalign_q <= (state_d == ST_ERR);
         if (state_d == ST_ERR) inst_q.pc <= pc_d;
`endif
      end
   end

   assign bus.ena          = ena_q;
   assign bus.curr_pc      = pc_q;
   assign bus.if_req_valid = req_valid_q;
   assign bus.if_req_addr  = pc_q;
   assign bus.inst_valid   = inst_valid_q;
   assign bus.inst_data    = inst_q.data;
   assign bus.inst_pc      = inst_q.pc;
`ifdef PC_ALIGN_CHECK_EN
   assign bus.fetch_misalign = misalign_q;
`else
   assign bus.fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: expected fetch addresses and delivered
// instructions are queued as stimulus is applied and popped as the DUT produces them.
module tb_pc_fetch_ctrl;
   import pc_fetch_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pc_fetch_ctrl_if bus ();

   pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned cyc   = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_inst_q[$];
   int unsigned hs_cyc_q[$];
   int          req_grant = 0;
   int          n_acc     = 0;
   int          rsp_lat   = 0;
   bit          rsp_pend  = 1'b0;
   int          rsp_cnt   = 0;
   logic [31:0] rsp_addr  = '0;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int max, input string tag);
      for (int i = 0; i < max; i++) begin
         if (exp_addr_q.size() == 0 && exp_inst_q.size() == 0) break;
         tick();
      end
      chk_eq({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
      chk_eq({tag, "_inst_left"}, 32'(exp_inst_q.size()), 32'd0);
   endtask

   task automatic wait_accept(input int max, input string tag);
      for (int i = 0; i < max; i++) begin
         if (exp_addr_q.size() == 0) break;
         tick();
      end
      chk_eq({tag, "_accepted"}, 32'(exp_addr_q.size()), 32'd0);
   endtask

   task automatic wait_inst_valid(input int max, input string tag);
      for (int i = 0; i < max; i++) begin
         if (bus.inst_valid === 1'b1) break;
         tick();
      end
      chk_eq(tag, 32'(bus.inst_valid), 32'd1);
   endtask

   // imem + decode monitor: sample mid-cycle, drive just after the rising edge
   initial begin
      bus.if_req_ready = 1'b0;
      bus.if_rsp_valid = 1'b0;
      bus.if_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.if_req_valid && bus.if_req_ready) begin
               if (exp_addr_q.size() == 0) chk_eq("req_extra", 32'(exp_addr_q.size()), 32'd1);
               else chk_eq("req_addr", bus.if_req_addr, exp_addr_q.pop_front());
               n_acc++;
               rsp_pend = 1'b1;
               rsp_cnt  = rsp_lat;
               rsp_addr = bus.if_req_addr;
            end
            if (bus.inst_valid && bus.inst_ready && !bus.trap_valid && !bus.br_taken) begin
               hs_cyc_q.push_back(cyc);
               if (exp_inst_q.size() == 0) chk_eq("inst_extra", 32'(exp_inst_q.size()), 32'd1);
               else begin
                  logic [31:0] epc;
                  epc = exp_inst_q.pop_front();
                  chk_eq("inst_pc", bus.inst_pc, epc);
                  chk_eq("inst_data", bus.inst_data, imem_word(epc));
               end
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         bus.if_rsp_valid = 1'b0;
         if (rsp_pend) begin
            if (rsp_cnt == 0) begin
               bus.if_rsp_valid = 1'b1;
               bus.if_rsp_data  = imem_word(rsp_addr);
               rsp_pend         = 1'b0;
            end else begin
               rsp_cnt--;
            end
         end
         bus.if_req_ready = (n_acc < req_grant);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n          = 1'b0;
      bus.trap_valid = 1'b0;
      bus.trap_vec   = '0;
      bus.br_taken   = 1'b0;
      bus.br_target  = '0;
      bus.inst_ready = 1'b0;
      repeat (3) tick();

      // reset state
      chk_eq("rst_ena", 32'(bus.ena), 32'd0);
      chk_eq("rst_req_valid", 32'(bus.if_req_valid), 32'd0);
      chk_eq("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk_eq("rst_curr_pc", bus.curr_pc, 32'h0);
      chk_eq("rst_inst_data", bus.inst_data, 32'h0);
      chk_eq("rst_inst_pc", bus.inst_pc, 32'h0);
      chk_eq("rst_misalign", 32'(bus.fetch_misalign), 32'd0);

      // sequential fetch 0,4,8 at full rate
      exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
      exp_inst_q.push_back(32'h0); exp_inst_q.push_back(32'h4); exp_inst_q.push_back(32'h8);
      req_grant += 3;
      bus.inst_ready = 1'b1;
      rst_n = 1'b1;
      chk_eq("idle_ena", 32'(bus.ena), 32'd0);
      tick();
      chk_eq("ena_on", 32'(bus.ena), 32'd1);
      wait_drain(40, "basic");
      chk_eq("hs_cnt", 32'(hs_cyc_q.size()), 32'd3);
      if (hs_cyc_q.size() >= 3) begin
         chk_eq("thru_01", hs_cyc_q[1] - hs_cyc_q[0], 32'd3);
         chk_eq("thru_12", hs_cyc_q[2] - hs_cyc_q[1], 32'd3);
      end

      // decode stall in HOLD
      bus.inst_ready = 1'b0;
      exp_addr_q.push_back(32'hC); exp_inst_q.push_back(32'hC);
      req_grant += 1;
      wait_inst_valid(20, "stall_hold_seen");
      repeat (5) begin
         chk_eq("stall_inst_pc", bus.inst_pc, 32'hC);
         chk_eq("stall_inst_data", bus.inst_data, imem_word(32'hC));
         chk_eq("stall_no_req", 32'(bus.if_req_valid), 32'd0);
         chk_eq("stall_curr_pc", bus.curr_pc, 32'hC);
         tick();
      end
      exp_addr_q.push_back(32'h10); exp_inst_q.push_back(32'h10);
      req_grant += 1;
      bus.inst_ready = 1'b1;
      wait_drain(40, "stall_go");
      chk_eq("stall_pc_adv", bus.curr_pc, 32'h14);
      chk_eq("stall_req_addr", bus.if_req_addr, 32'h14);

      // branch while waiting on imem: old response must be dropped
      rsp_lat = 2;
      exp_addr_q.push_back(32'h14);
      req_grant += 1;
      wait_accept(20, "br_old");
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h100;
      tick();
      bus.br_taken = 1'b0;
      exp_addr_q.push_back(32'h100); exp_inst_q.push_back(32'h100);
      req_grant += 1;
      wait_drain(40, "br_wait");
      rsp_lat = 0;

      // trap and branch together in HOLD with decode ready: trap wins, no handshake
      bus.inst_ready = 1'b0;
      exp_addr_q.push_back(32'h104);
      req_grant += 1;
      wait_inst_valid(20, "trap_hold_seen");
      bus.trap_valid = 1'b1; bus.trap_vec  = 32'h80;
      bus.br_taken   = 1'b1; bus.br_target = 32'h200;
      bus.inst_ready = 1'b1;
      tick();
      bus.trap_valid = 1'b0;
      bus.br_taken   = 1'b0;
      chk_eq("trap_inst_drop", 32'(bus.inst_valid), 32'd0);
      chk_eq("trap_curr_pc", bus.curr_pc, 32'h80);
      chk_eq("trap_req_addr", bus.if_req_addr, 32'h80);
      exp_addr_q.push_back(32'h80); exp_inst_q.push_back(32'h80);
      req_grant += 1;
      wait_drain(40, "trap");

      // wrap from the top of the address space
      bus.br_taken  = 1'b1;
      bus.br_target = 32'hFFFF_FFFC;
      tick();
      bus.br_taken = 1'b0;
      chk_eq("wrap_req_addr", bus.if_req_addr, 32'hFFFF_FFFC);
      exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0);
      exp_inst_q.push_back(32'hFFFF_FFFC); exp_inst_q.push_back(32'h0);
      req_grant += 2;
      wait_drain(40, "wrap");
      chk_eq("wrap_curr_pc", bus.curr_pc, 32'h4);

      // reset while waiting; the late response lands in IDLE and is ignored
      rsp_lat = 4;
      exp_addr_q.push_back(32'h4);
      req_grant += 1;
      wait_accept(20, "rst_fetch");
      rst_n = 1'b0;
      tick(); tick();
      chk_eq("rst2_ena", 32'(bus.ena), 32'd0);
      chk_eq("rst2_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk_eq("rst2_inst_data", bus.inst_data, 32'h0);
      chk_eq("rst2_inst_pc", bus.inst_pc, 32'h0);
      chk_eq("rst2_curr_pc", bus.curr_pc, 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      rsp_lat = 0;
      exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4);
      exp_inst_q.push_back(32'h0); exp_inst_q.push_back(32'h4);
      req_grant += 2;
      wait_drain(40, "restart");

`ifdef PC_ALIGN_CHECK_EN
      // misaligned branch target: no request, exception held until redirect
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h102;
      tick();
      bus.br_taken = 1'b0;
      req_grant += 1;
      repeat (3) begin
         chk_eq("mis_flag", 32'(bus.fetch_misalign), 32'd1);
         chk_eq("mis_no_req", 32'(bus.if_req_valid), 32'd0);
         chk_eq("mis_inst_pc", bus.inst_pc, 32'h102);
         tick();
      end
      bus.trap_valid = 1'b1;
      bus.trap_vec   = 32'h40;
      tick();
      bus.trap_valid = 1'b0;
      chk_eq("mis_clear", 32'(bus.fetch_misalign), 32'd0);
      exp_addr_q.push_back(32'h40); exp_inst_q.push_back(32'h40);
      wait_drain(40, "mis_recover");
`endif

      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
